// File: rtl/imsic_msi_recv.sv
// rtl/imsic_msi_recv.sv - CSR-domain receiver for IMSIC MSI info with 2-entry setipnum queue
//
// Purpose:
//   Synchronises the asynchronous level valid from the IMSIC register-map/FIFO
//   stage. It turns each high level into one event and samples the (stable)
//   info bus on that event. It checks the hart, file and source fields. Legal
//   events are queued as {file one-hot, src} in a 2-entry valid/ready queue
//   for the interrupt-file logic.
//
// Optional build macro:
//   IMSIC_MSI_RECV_SYNC3_EN - use a 3-flop synchroniser instead of 2 flops.
//
// Ports:
//   clk              CSR-domain clock
//   rstn             asynchronous active-low reset
//   i_hart_id        index of this hart (quasi-static)
//   i_msi_info       {hart, file, src} from the source domain
//   i_msi_info_vld   asynchronous level valid for i_msi_info
//   o_setipnum       source number at the queue head (0 when empty)
//   o_setipnum_file  one-hot target file at the queue head (0 when empty)
//   o_setipnum_vld   queue head valid
//   i_setipnum_rdy   consumer accepts the head
//   o_ovf            sticky overflow flag
//   i_ovf_clr        clears o_ovf (a same-cycle set wins)
//   o_ill_cnt        saturating count of illegal or mismatched events

module imsic_msi_recv #(
  parameter int NR_SRC_WIDTH    = 5,
  parameter int NR_HARTS_WIDTH  = 6,
  parameter int INTP_FILE_WIDTH = 3,
  parameter int NR_INTP_FILES   = 7,
  parameter int MSI_INFO_WIDTH  = 14
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [NR_HARTS_WIDTH-1:0] i_hart_id,
  input  logic [MSI_INFO_WIDTH-1:0] i_msi_info,
  input  logic                      i_msi_info_vld,
  output logic [NR_SRC_WIDTH-1:0]   o_setipnum,
  output logic [NR_INTP_FILES-1:0]  o_setipnum_file,
  output logic                      o_setipnum_vld,
  input  logic                      i_setipnum_rdy,
  output logic                      o_ovf,
  input  logic                      i_ovf_clr,
  output logic [7:0]                o_ill_cnt
);

  localparam int ENTRY_W = NR_INTP_FILES + NR_SRC_WIDTH;

  // ---------------------------------------------------------------------------
  // Valid synchroniser and rising-edge event detect
  // ---------------------------------------------------------------------------
  logic sync1, sync2, sync_d, sync_last, ev;

`ifdef IMSIC_MSI_RECV_SYNC3_EN
  logic sync3;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      sync3  <= 1'b0;
      sync_d <= 1'b0;
    end else begin
      sync1  <= i_msi_info_vld;
      sync2  <= sync1;
      sync3  <= sync2;
      sync_d <= sync3;
    end
  end

  assign sync_last = sync3;
`else
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      sync_d <= 1'b0;
    end else begin
      sync1  <= i_msi_info_vld;
      sync2  <= sync1;
      sync_d <= sync2;
    end
  end

  assign sync_last = sync2;
`endif

  assign ev = sync_last & ~sync_d;

  // ---------------------------------------------------------------------------
  // Field decode and legality. The info bus has been stable for several
  // cycles by the time ev fires, so it is sampled directly without a
  // synchroniser.
  // ---------------------------------------------------------------------------
  logic [NR_SRC_WIDTH-1:0]    info_src;
  logic [INTP_FILE_WIDTH-1:0] info_file;
  logic [NR_HARTS_WIDTH-1:0]  info_hart;
  logic [NR_INTP_FILES-1:0]   file_oh;
  logic                       legal;

  assign info_src  = i_msi_info[NR_SRC_WIDTH-1:0];
  assign info_file = i_msi_info[NR_SRC_WIDTH +: INTP_FILE_WIDTH];
  assign info_hart = i_msi_info[NR_SRC_WIDTH+INTP_FILE_WIDTH +: NR_HARTS_WIDTH];

  assign legal = (info_hart == i_hart_id) &&
                 (32'(info_file) < NR_INTP_FILES) &&
                 (info_src != '0);

  // Out-of-range file indices shift the bit out entirely. They are illegal,
  // so the value is never stored.
  assign file_oh = {{(NR_INTP_FILES-1){1'b0}}, 1'b1} << info_file;

  // ---------------------------------------------------------------------------
  // 2-entry queue
  // ---------------------------------------------------------------------------
  logic [ENTRY_W-1:0] q_mem [2];
  logic               q_wptr, q_rptr;
  logic [1:0]         q_cnt;
  logic               q_empty, q_full;
  logic               push_req, push, pop, ovf_set;

  assign q_empty  = (q_cnt == 2'd0);
  assign q_full   = (q_cnt == 2'd2);
  assign pop      = ~q_empty & i_setipnum_rdy;
  assign push_req = ev & legal;
  // On a full queue a same-cycle pop frees the slot being written.
  assign push     = push_req & (~q_full | pop);
  assign ovf_set  = push_req & q_full & ~pop;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q_wptr <= 1'b0;
      q_rptr <= 1'b0;
      q_cnt  <= 2'd0;
    end else begin
      if (push) q_wptr <= ~q_wptr;
      if (pop)  q_rptr <= ~q_rptr;
      case ({push, pop})
        2'b10:   q_cnt <= q_cnt + 2'd1;
        2'b01:   q_cnt <= q_cnt - 2'd1;
        default: q_cnt <= q_cnt;
      endcase
    end
  end

  // Storage needs no reset: outputs are masked while the queue is empty.
  always_ff @(posedge clk) begin
    if (push) q_mem[q_wptr] <= {file_oh, info_src};
  end

  assign o_setipnum_vld = ~q_empty;
  assign {o_setipnum_file, o_setipnum} = q_empty ? '0 : q_mem[q_rptr];

  // ---------------------------------------------------------------------------
  // Status: sticky overflow and saturating illegal-event counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_ovf     <= 1'b0;
      o_ill_cnt <= 8'd0;
    end else begin
      if (ovf_set)
        o_ovf <= 1'b1;
      else if (i_ovf_clr)
        o_ovf <= 1'b0;

      if (ev && !legal && o_ill_cnt != 8'hFF)
        o_ill_cnt <= o_ill_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_imsic_msi_recv.sv
// tb/tb_imsic_msi_recv.sv - directed self-checking bench for imsic_msi_recv

module tb_imsic_msi_recv;

`ifdef IMSIC_MSI_RECV_SYNC3_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif
  localparam int HIGH = 8;
  localparam int GAP  = 6;

  logic        clk = 1'b0;
  logic        rstn;
  logic [5:0]  i_hart_id;
  logic [13:0] i_msi_info;
  logic        i_msi_info_vld;
  logic [4:0]  o_setipnum;
  logic [6:0]  o_setipnum_file;
  logic        o_setipnum_vld;
  logic        i_setipnum_rdy;
  logic        o_ovf;
  logic        i_ovf_clr;
  logic [7:0]  o_ill_cnt;

  int checks = 0;
  int errors = 0;

  imsic_msi_recv dut (
    .clk             (clk),
    .rstn            (rstn),
    .i_hart_id       (i_hart_id),
    .i_msi_info      (i_msi_info),
    .i_msi_info_vld  (i_msi_info_vld),
    .o_setipnum      (o_setipnum),
    .o_setipnum_file (o_setipnum_file),
    .o_setipnum_vld  (o_setipnum_vld),
    .i_setipnum_rdy  (i_setipnum_rdy),
    .o_ovf           (o_ovf),
    .i_ovf_clr       (i_ovf_clr),
    .o_ill_cnt       (o_ill_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [13:0] mk(input int hart, input int file, input int src);
    return {6'(hart), 3'(file), 5'(src)};
  endfunction

  // Called at a negedge; one high level followed by a low gap.
  task automatic send(input logic [13:0] info);
    i_msi_info     = info;
    i_msi_info_vld = 1'b1;
    repeat (HIGH) @(negedge clk);
    i_msi_info_vld = 1'b0;
    repeat (GAP) @(negedge clk);
  endtask

  task automatic check_head(input string tag, input int src, input int oh);
    check({tag, "_vld"}, 32'(o_setipnum_vld), 32'd1);
    check({tag, "_src"}, 32'(o_setipnum), 32'(src));
    check({tag, "_file"}, 32'(o_setipnum_file), 32'(oh));
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_vld"}, 32'(o_setipnum_vld), 32'd0);
    check({tag, "_src"}, 32'(o_setipnum), 32'd0);
    check({tag, "_file"}, 32'(o_setipnum_file), 32'd0);
  endtask

  initial begin
    rstn           = 1'b0;
    i_hart_id      = 6'd5;
    i_msi_info     = '0;
    i_msi_info_vld = 1'b0;
    i_setipnum_rdy = 1'b0;
    i_ovf_clr      = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check_idle("rst");
    check("rst_ovf", 32'(o_ovf), 32'd0);
    check("rst_ill", 32'(o_ill_cnt), 32'd0);
    rstn = 1'b1;
    @(negedge clk);

    // Basic event with latency check: {hart 5, file 0, src 9}
    i_msi_info     = mk(5, 0, 9);
    i_msi_info_vld = 1'b1;
    for (int i = 1; i <= LAT; i++) begin
      @(negedge clk);
      check($sformatf("lat_e%0d", i), 32'(o_setipnum_vld), (i == LAT) ? 32'd1 : 32'd0);
    end
    check_head("basic", 9, 7'b0000001);
    i_setipnum_rdy = 1'b1;
    @(negedge clk);
    i_setipnum_rdy = 1'b0;
    check_idle("basic_pop");
    repeat (HIGH - LAT - 1) @(negedge clk);
    i_msi_info_vld = 1'b0;
    repeat (GAP) @(negedge clk);
    check("basic_single", 32'(o_setipnum_vld), 32'd0);
    check("basic_ill", 32'(o_ill_cnt), 32'd0);
    check("basic_ovf", 32'(o_ovf), 32'd0);

    // Illegal events: wrong hart, file out of range, src 0
    send(mk(4, 0, 9));
    send(mk(5, 7, 9));
    send(mk(5, 0, 0));
    check("ill_vld", 32'(o_setipnum_vld), 32'd0);
    check("ill_cnt3", 32'(o_ill_cnt), 32'd3);

    // Overflow: three legal events with consumer stalled
    send(mk(5, 0, 1));
    send(mk(5, 2, 2));
    send(mk(5, 1, 3));
    check_head("ovf_h1", 1, 7'b0000001);
    check("ovf_set", 32'(o_ovf), 32'd1);
    i_setipnum_rdy = 1'b1;
    @(negedge clk);
    check_head("ovf_h2", 2, 7'b0000100);
    @(negedge clk);
    i_setipnum_rdy = 1'b0;
    check_idle("ovf_empty");
    check("ovf_sticky", 32'(o_ovf), 32'd1);
    i_ovf_clr = 1'b1;
    @(negedge clk);
    i_ovf_clr = 1'b0;
    check("ovf_clr", 32'(o_ovf), 32'd0);

    // Full queue, pop on the same edge as the push of src 4
    send(mk(5, 0, 1));
    send(mk(5, 0, 2));
    check_head("fp_full", 1, 7'b0000001);
    i_msi_info     = mk(5, 3, 4);
    i_msi_info_vld = 1'b1;
    repeat (LAT - 1) @(negedge clk);
    i_setipnum_rdy = 1'b1;
    @(negedge clk);
    i_setipnum_rdy = 1'b0;
    check("fp_no_ovf", 32'(o_ovf), 32'd0);
    check_head("fp_h2", 2, 7'b0000001);
    i_setipnum_rdy = 1'b1;
    @(negedge clk);
    check_head("fp_h4", 4, 7'b0001000);
    @(negedge clk);
    i_setipnum_rdy = 1'b0;
    check_idle("fp_empty");
    repeat (HIGH) @(negedge clk);
    i_msi_info_vld = 1'b0;
    repeat (GAP) @(negedge clk);
    check("fp_ill", 32'(o_ill_cnt), 32'd3);

    // Saturation of the illegal counter
    for (int i = 0; i < 260; i++) send(mk(4, 0, 1));
    check("sat_cnt", 32'(o_ill_cnt), 32'd255);
    check("sat_vld", 32'(o_setipnum_vld), 32'd0);

    // Reset mid-operation with valid held high
    i_msi_info     = mk(5, 0, 7);
    i_msi_info_vld = 1'b1;
    repeat (LAT + 1) @(negedge clk);
    check_head("mr_pre", 7, 7'b0000001);
    rstn = 1'b0;
    #1;
    check_idle("mr_rst");
    check("mr_rst_ovf", 32'(o_ovf), 32'd0);
    check("mr_rst_ill", 32'(o_ill_cnt), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (LAT - 1) @(negedge clk);
    check("mr_early", 32'(o_setipnum_vld), 32'd0);
    @(negedge clk);
    check_head("mr_post", 7, 7'b0000001);
    i_setipnum_rdy = 1'b1;
    @(negedge clk);
    i_setipnum_rdy = 1'b0;
    repeat (8) @(negedge clk);
    check("mr_once", 32'(o_setipnum_vld), 32'd0);
    i_msi_info_vld = 1'b0;
    repeat (GAP) @(negedge clk);
    check("mr_ill", 32'(o_ill_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imsic_msi_recv.md
Name: imsic_msi_recv

Overview:
- Destination-domain receiver for the MSI info produced by the IMSIC register-map/FIFO stage. That producer holds its info bus stable while it keeps its valid high for several source-domain cycles.
- This block sits in the CSR clock domain and performs these steps:
  - synchronises the valid;
  - detects each new event and captures the info bus;
  - checks hart, file and source;
  - presents each legal setipnum to the CSR interrupt-file logic through a 2-entry valid/ready queue.

Parameters:
- NR_SRC_WIDTH, 5: width of the interrupt identity (source number) field.
- NR_HARTS_WIDTH, 6: width of the hart-index field.
- INTP_FILE_WIDTH, 3: width of the file-index field (0 = M file, 1.. = S/VS files).
- NR_INTP_FILES, 7: number of interrupt files per hart; must be greater than 2.
- MSI_INFO_WIDTH, 14: must equal NR_HARTS_WIDTH+INTP_FILE_WIDTH+NR_SRC_WIDTH. Field layout is {hart, file, src}, with src at the LSBs.

Ports:
- clk, input, 1: CSR-domain clock.
- rstn, input, 1: asynchronous active-low reset.
- i_hart_id, input, NR_HARTS_WIDTH: index of this hart; quasi-static.
- i_msi_info, input, MSI_INFO_WIDTH: MSI info from the source domain; stable whenever i_msi_info_vld is high.
- i_msi_info_vld, input, 1: asynchronous level valid.
- o_setipnum, output, NR_SRC_WIDTH: source number to set pending.
- o_setipnum_file, output, NR_INTP_FILES: one-hot target interrupt file.
- o_setipnum_vld, output, 1: queue head valid.
- i_setipnum_rdy, input, 1: consumer accepts the head.
- o_ovf, output, 1: sticky queue-overflow flag.
- i_ovf_clr, input, 1: clears o_ovf.
- o_ill_cnt, output, 8: saturating count of illegal or mismatched events.

Behaviour:
- Reset values: all outputs are 0; synchroniser flops, queue pointers and count are all 0.
- Synchroniser:
  - 2-flop chain sync1→sync2, plus history flop sync_d.
  - Event pulse ev = sync2 & ~sync_d.
  - Each high level of i_msi_info_vld yields exactly one ev.
- Source-side requirement: each high level and each low gap of i_msi_info_vld lasts ≥3 clk cycles. This requirement belongs to the source domain and is not checked here.
- Capture: on the clk edge where ev=1, i_msi_info is sampled directly; it is stable by the source-side rule.
- Legality, evaluated on the sampled info (event is legal only if all hold):
  - hart field == i_hart_id;
  - file field ≤ NR_INTP_FILES-1;
  - src field != 0 (identity 0 is reserved).
- Illegal events:
  - Never enqueued.
  - o_ill_cnt increments by 1 and saturates at 255.
- Legal events:
  - Pushed into a 2-entry FIFO of {file one-hot, src}.
  - The one-hot is 1<<file.
- Latency: with i_msi_info_vld first sampled high at edge E1, o_setipnum_vld=1 after edge E3 when the queue was empty.
- Handshake:
  - Head pops on a clk edge where o_setipnum_vld & i_setipnum_rdy.
  - o_setipnum and o_setipnum_file are driven from the head entry and are 0 when the queue is empty.
  - The head stays stable until popped.
- Full queue:
  - A legal event arriving while 2 entries are held and no pop occurs in the same cycle is dropped, and o_ovf is set.
  - If a pop and a push occur in the same cycle on a full queue, the push is accepted; there is no overflow.
  - Push and pop on an empty queue in the same cycle cannot occur, because the head is registered.
- Overflow flag: o_ovf clears on i_ovf_clr; set wins over clear in the same cycle.
- Reset mid-operation: the queue empties immediately, and a level on i_msi_info_vld that is still high after reset release produces one ev, once sync2 rises.
- Queue pointers: 1-bit pointers wrap modulo 2; occupancy count is 0..2.

Optional Feature:
- Macro IMSIC_MSI_RECV_SYNC3_EN.
- Defined: 3-flop synchroniser (sync1→sync2→sync3, ev = sync3 & ~sync_d). Latency becomes E4, and the minimum high/low level required from the source becomes ≥4 clk cycles.
- Undefined: the 2-flop behaviour described above.

Test Plan:
- Basic event: i_hart_id=5, info={hart 5, file 0, src 9}, vld high for 8 cycles → single o_setipnum_vld at E3 with o_setipnum=9 and o_setipnum_file=7'b0000001; rdy=1 pops it next cycle; o_ill_cnt stays 0.
- Illegal events: info hart=4 (hart 5 expected), then file=7, then src=0 → no o_setipnum_vld; o_ill_cnt=3.
- Overflow: rdy=0, three legal events (src 1, 2, 3) → queue holds 1, 2; o_ovf=1. Then raise rdy → outputs 1 then 2, then vld drops. Pulse i_ovf_clr → o_ovf=0.
- Full push/pop: full queue with rdy=1 on the same edge as ev for src 4 → no overflow; sequence observed is 2, 4.
- Saturation and reset: 260 illegal events → o_ill_cnt=255. Assert rstn low with vld held high → all outputs 0; after release, exactly one event.
- SYNC3 build: repeat the basic event → o_setipnum_vld at E4.
